// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the two-requester data memory arbiter.
// Holds the bus scalar types, FSM state encoding and grant/owner codes.
package data_mem_arbiter_pkg;

    typedef logic        clock_t;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic        bool_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

    localparam int unsigned DEFAULT_MEM_BYTES = 512;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_A    = 2'b01;
    localparam logic [1:0] GRANT_B    = 2'b10;

    function automatic bool_t addr_in_range(input addr_t addr, input int unsigned mem_bytes);
        return addr < addr_t'(mem_bytes);
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of requester A/B handshakes, shared response data and memory port.
// slave = arbiter side, master = requesters plus memory.
interface data_mem_arbiter_if;
    import data_mem_arbiter_pkg::*;

    bool_t a_req_valid;
    bool_t a_req_ready;
    addr_t a_req_addr;
    data_t a_req_wdata;
    bool_t a_req_we;
    bool_t a_resp_valid;
    bool_t a_resp_ready;

    bool_t b_req_valid;
    bool_t b_req_ready;
    addr_t b_req_addr;
    data_t b_req_wdata;
    bool_t b_req_we;
    bool_t b_resp_valid;
    bool_t b_resp_ready;

    data_t resp_rdata;
    bool_t resp_err;

    addr_t mem_idx;
    data_t mem_write_data;
    bool_t mem_write_enable;
    data_t mem_read_data;

    modport slave (
        input  a_req_valid, a_req_addr, a_req_wdata, a_req_we, a_resp_ready,
        input  b_req_valid, b_req_addr, b_req_wdata, b_req_we, b_resp_ready,
        input  mem_read_data,
        output a_req_ready, a_resp_valid, b_req_ready, b_resp_valid,
        output resp_rdata, resp_err,
        output mem_idx, mem_write_data, mem_write_enable
    );

    modport master (
        output a_req_valid, a_req_addr, a_req_wdata, a_req_we, a_resp_ready,
        output b_req_valid, b_req_addr, b_req_wdata, b_req_we, b_resp_ready,
        output mem_read_data,
        input  a_req_ready, a_resp_valid, b_req_ready, b_resp_valid,
        input  resp_rdata, resp_err,
        input  mem_idx, mem_write_data, mem_write_enable
    );

endinterface

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin select; req[0]=A, req[1]=B, grant is one-hot.
// last=0 means A was granted last, last=1 means B was granted last.
module rr_arbiter2
    import data_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = GRANT_NONE;
        case (req)
            2'b01:   grant = GRANT_A;
            2'b10:   grant = GRANT_B;
            2'b11:   grant = last ? GRANT_A : GRANT_B;
            default: grant = GRANT_NONE;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates two requesters onto one data memory port, one access per three cycles.
// Out-of-range accesses are answered with an error and never reach memory.
//
// state     | meaning
// ST_IDLE   | waiting for a request; grant and latch it combinationally
// ST_ACCESS | single memory cycle; write strobe / read data capture
// ST_RESP   | owner's resp_valid high until it is consumed
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES
) (
    input  clock_t              clk,
    input  logic                rst_n,
    data_mem_arbiter_if.slave   bus
);

    arb_state_e state_q;
    arb_state_e state_d;

    owner_e last_q;
    owner_e owner_q;
    addr_t  addr_q;
    data_t  wdata_q;
    bool_t  we_q;
    data_t  rdata_q;
    bool_t  err_q;

    logic [1:0] req;
    logic [1:0] grant;
    logic       in_range;
    logic       owner_ready;
    logic       load;
    logic       resp_done;

    logic a_req_ready_c;
    logic b_req_ready_c;
    logic a_resp_valid_c;
    logic b_resp_valid_c;
    logic mem_we_c;

    assign req = {bus.b_req_valid, bus.a_req_valid};

    rr_arbiter2 u_rr (
        .req   (req),
        .last  (last_q == OWNER_B),
        .grant (grant)
    );

    assign in_range    = addr_in_range(addr_q, MEM_BYTES);
    assign owner_ready = (owner_q == OWNER_A) ? bus.a_resp_ready : bus.b_resp_ready;

    always_comb begin
        state_d        = state_q;
        a_req_ready_c  = 1'b0;
        b_req_ready_c  = 1'b0;
        a_resp_valid_c = 1'b0;
        b_resp_valid_c = 1'b0;
        mem_we_c       = 1'b0;
        load           = 1'b0;
        resp_done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Ready is gated by rst_n so a held valid cannot be acknowledged during reset.
                if (grant != GRANT_NONE && rst_n) begin
                    load          = 1'b1;
                    a_req_ready_c = grant[0];
                    b_req_ready_c = grant[1];
                    state_d       = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_we_c = we_q && in_range;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                a_resp_valid_c = (owner_q == OWNER_A);
                b_resp_valid_c = (owner_q == OWNER_B);
                if (owner_ready) begin
                    resp_done = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= OWNER_B;
            owner_q <= OWNER_A;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                if (grant[1]) begin
                    owner_q <= OWNER_B;
                    addr_q  <= bus.b_req_addr;
                    wdata_q <= bus.b_req_wdata;
                    we_q    <= bus.b_req_we;
                end else begin
                    owner_q <= OWNER_A;
                    addr_q  <= bus.a_req_addr;
                    wdata_q <= bus.a_req_wdata;
                    we_q    <= bus.a_req_we;
                end
            end
            if (state_q == ST_ACCESS) begin
                err_q   <= !in_range;
                rdata_q <= (!we_q && in_range) ? bus.mem_read_data : '0;
            end
            // Fairness pointer only advances once the response is actually consumed.
            if (resp_done) begin
                last_q <= owner_q;
            end
        end
    end

    assign bus.a_req_ready      = a_req_ready_c;
    assign bus.b_req_ready      = b_req_ready_c;
    assign bus.a_resp_valid     = a_resp_valid_c;
    assign bus.b_resp_valid     = b_resp_valid_c;
    assign bus.resp_rdata       = rdata_q;
    assign bus.resp_err         = err_q;
    assign bus.mem_idx          = addr_q;
    assign bus.mem_write_data   = wdata_q;
    assign bus.mem_write_enable = mem_we_c;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: drivers push expected responses on acceptance,
// a negedge monitor pops and compares on every response handshake.
module tb_data_mem_arbiter;
    import data_mem_arbiter_pkg::*;

    localparam int unsigned MEM_BYTES = 512;
    localparam int MEM_WORDS = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    data_mem_arbiter_if bus();

    data_mem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        owner;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    bit   grant_log[$];
    exp_t mon_e;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int we_cnt = 0;
    bit mem_init = 1'b1;
    bit seen = 1'b0;
    logic [31:0] mem [MEM_WORDS];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_write_enable) we_cnt <= we_cnt + 1;
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        end else if (bus.mem_write_enable) begin
            mem[bus.mem_idx[8:2]] <= bus.mem_write_data;
        end
    end

    assign bus.mem_read_data = mem[bus.mem_idx[8:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            seen <= 1'b0;
        end else if (bus.a_resp_valid || bus.b_resp_valid) begin
            if (!seen) begin
                seen <= 1'b1;
                check("resp_latency", 32'(cyc - accept_cyc), 32'd2);
            end
            check("resp_onehot", 32'(bus.a_resp_valid & bus.b_resp_valid), 32'd0);
            if ((bus.a_resp_valid && bus.a_resp_ready) || (bus.b_resp_valid && bus.b_resp_ready)) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: actual=one response required=none");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_owner", 32'(bus.b_resp_valid), 32'(mon_e.owner));
                    check("resp_rdata", bus.resp_rdata, mon_e.rdata);
                    check("resp_err", 32'(bus.resp_err), 32'(mon_e.err));
                end
                seen <= 1'b0;
            end
        end
    end

    task automatic issue(input bit who, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit we, input logic [31:0] exp_rdata, input bit exp_err);
        bit   accepted;
        exp_t ent;
        accepted = 1'b0;
        if (who == 1'b0) begin
            bus.a_req_valid = 1'b1; bus.a_req_addr = addr; bus.a_req_wdata = wdata; bus.a_req_we = we;
        end else begin
            bus.b_req_valid = 1'b1; bus.b_req_addr = addr; bus.b_req_wdata = wdata; bus.b_req_we = we;
        end
        for (int n = 0; n < 30 && !accepted; n++) begin
            @(negedge clk);
            if (rst_n && ((who == 1'b0 && bus.a_req_ready) || (who == 1'b1 && bus.b_req_ready))) begin
                accepted   = 1'b1;
                ent.owner  = who;
                ent.rdata  = exp_rdata;
                ent.err    = exp_err;
                exp_q.push_back(ent);
                grant_log.push_back(who);
                accept_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        if (who == 1'b0) bus.a_req_valid = 1'b0;
        else             bus.b_req_valid = 1'b0;
        if (!accepted) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: actual=not accepted required=accepted requester=%0d", who);
        end
    endtask

    task automatic wait_done();
        for (int n = 0; n < 30 && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: actual=%0d pending required=0 pending", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int w0;
        bus.a_req_valid = 1'b0; bus.a_req_addr = '0; bus.a_req_wdata = '0; bus.a_req_we = 1'b0;
        bus.b_req_valid = 1'b0; bus.b_req_addr = '0; bus.b_req_wdata = '0; bus.b_req_we = 1'b0;
        bus.a_resp_ready = 1'b1;
        bus.b_resp_ready = 1'b1;

        // Reset state, with both requesters already asking.
        repeat (2) @(posedge clk);
        #1;
        bus.a_req_valid = 1'b1;
        bus.b_req_valid = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {30'd0, bus.b_req_ready, bus.a_req_ready}, 32'd0);
        check("rst_resp_valid", {30'd0, bus.b_resp_valid, bus.a_resp_valid}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_mem_idx", bus.mem_idx, 32'd0);
        check("rst_mem_wdata", bus.mem_write_data, 32'd0);
        check("rst_mem_we", 32'(bus.mem_write_enable), 32'd0);
        bus.a_req_valid = 1'b0;
        bus.b_req_valid = 1'b0;
        @(posedge clk);
        #1;
        mem_init = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write then read back through A.
        w0 = we_cnt;
        issue(1'b0, 32'h8, 32'h1234, 1'b1, 32'h0, 1'b0);
        check("t1_access_idx", bus.mem_idx, 32'h8);
        check("t1_access_wdata", bus.mem_write_data, 32'h1234);
        check("t1_access_we", 32'(bus.mem_write_enable), 32'd1);
        @(posedge clk);
        #1;
        check("t1_resp_we", 32'(bus.mem_write_enable), 32'd0);
        check("t1_resp_idx_hold", bus.mem_idx, 32'h8);
        wait_done();
        check("t1_we_pulses", 32'(we_cnt - w0), 32'd1);
        check("t1_mem_word2", mem[2], 32'h1234);
        issue(1'b0, 32'h8, 32'h0, 1'b0, 32'h1234, 1'b0);
        wait_done();

        // Out-of-range write from B: error, no strobe, index-0 alias untouched.
        w0 = we_cnt;
        issue(1'b1, 32'h200, 32'hDEAD, 1'b1, 32'h0, 1'b1);
        wait_done();
        check("t3_we_pulses", 32'(we_cnt - w0), 32'd0);
        check("t3_mem_word0", mem[0], 32'hA500_0000);

        // Both requesters contending; B was granted last.
        grant_log.delete();
        fork
            begin
                issue(1'b0, 32'h10, 32'h0, 1'b0, 32'hA500_0004, 1'b0);
                issue(1'b0, 32'h7, 32'h0, 1'b0, 32'hA500_0001, 1'b0);
            end
            begin
                issue(1'b1, 32'h1FC, 32'h0, 1'b0, 32'hA500_007F, 1'b0);
                issue(1'b1, 32'h1F0, 32'hBEEF, 1'b1, 32'h0, 1'b0);
            end
        join
        wait_done();
        check("t2_grant_count", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4) begin
            check("t2_grant0", 32'(grant_log[0]), 32'd0);
            check("t2_grant1", 32'(grant_log[1]), 32'd1);
            check("t2_grant2", 32'(grant_log[2]), 32'd0);
            check("t2_grant3", 32'(grant_log[3]), 32'd1);
        end
        check("t2_mem_word124", mem[124], 32'hBEEF);

        // A stalls its response for 5 cycles while B waits.
        bus.a_resp_ready = 1'b0;
        issue(1'b0, 32'h8, 32'h0, 1'b0, 32'h1234, 1'b0);
        fork
            issue(1'b1, 32'h4, 32'h0, 1'b0, 32'hA500_0001, 1'b0);
            begin
                @(posedge clk);
                #1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("t4_a_resp_valid", 32'(bus.a_resp_valid), 32'd1);
                    check("t4_rdata_stable", bus.resp_rdata, 32'h1234);
                    check("t4_err_stable", 32'(bus.resp_err), 32'd0);
                    check("t4_b_req_ready", 32'(bus.b_req_ready), 32'd0);
                end
                @(posedge clk);
                #1;
                bus.a_resp_ready = 1'b1;
            end
        join
        wait_done();

        // Reset during a write access; A was granted last beforehand.
        issue(1'b0, 32'h4, 32'h0, 1'b0, 32'hA500_0001, 1'b0);
        wait_done();
        w0 = we_cnt;
        issue(1'b1, 32'h20, 32'h5555, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        check("t5_we_before_rst", 32'(bus.mem_write_enable), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_we_in_rst", 32'(bus.mem_write_enable), 32'd0);
        check("t5_rdata_in_rst", bus.resp_rdata, 32'd0);
        check("t5_idx_in_rst", bus.mem_idx, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t5_we_pulses", 32'(we_cnt - w0), 32'd0);
        check("t5_mem_word8", mem[8], 32'hA500_0008);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t5_no_resp", {30'd0, bus.b_resp_valid, bus.a_resp_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        grant_log.delete();
        fork
            issue(1'b0, 32'h7, 32'h0, 1'b0, 32'hA500_0001, 1'b0);
            issue(1'b1, 32'h10, 32'h0, 1'b0, 32'hA500_0004, 1'b0);
        join
        wait_done();
        check("t5_grant_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check("t5_first_grant", 32'(grant_log[0]), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter MEM_BYTES, default 512, SHALL set the byte size of the addressable data memory window.
REQ-002 clk  input  1  SHALL be the single clock, of type Clock; all state SHALL update on posedge clk.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 a_req_valid, b_req_valid  input  1 each  SHALL mark a pending request from requester A or B.
REQ-005 a_req_ready, b_req_ready  output  1 each  SHALL mark acceptance of the request in the current cycle.
REQ-006 a_req_addr, b_req_addr  input  32 (Addr)  SHALL carry the byte address.
REQ-007 a_req_wdata, b_req_wdata  input  32 (Data)  SHALL carry the write data.
REQ-008 a_req_we, b_req_we  input  1 (Bool) each  SHALL select write (1) or read (0).
REQ-009 a_resp_valid, b_resp_valid  output  1 each  SHALL mark a valid response to A or B.
REQ-010 a_resp_ready, b_resp_ready  input  1 each  SHALL mark that A or B consumes the response.
REQ-011 resp_rdata  output  32 (Data)  SHALL be the read data shared by both responses.
REQ-012 resp_err  output  1  SHALL flag an out-of-range access in the current response.
REQ-013 mem_idx  output  32 (Addr)  SHALL be the address to the data memory.
REQ-014 mem_write_data  output  32 (Data)  SHALL be the write data to the data memory.
REQ-015 mem_write_enable  output  1 (Bool)  SHALL be the write strobe to the data memory.
REQ-016 mem_read_data  input  32 (Data)  SHALL be the combinational read data from the data memory.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-018 In IDLE with any req_valid, the FSM SHALL grant one requester, assert only that requester's req_ready combinationally, latch its addr/wdata/we/owner, and go to ACCESS.
REQ-019 If both requesters are valid in IDLE, the grant SHALL go to the requester not granted last; after reset, A SHALL win.
REQ-020 If only one requester is valid, it SHALL be granted regardless of priority.
REQ-021 The priority pointer SHALL update only when a response completes.
REQ-022 In ACCESS for exactly one cycle, mem_idx SHALL equal the latched address, and mem_write_enable SHALL be high if and only if we=1 and addr < MEM_BYTES.
REQ-023 In ACCESS, mem_read_data SHALL be registered into resp_rdata on reads; on writes resp_rdata SHALL be 0.
REQ-024 Any address >= MEM_BYTES SHALL give resp_err=1 and resp_rdata=0, and SHALL NOT write memory.
REQ-025 addr[1:0] SHALL be ignored (word access only), with no error raised.
REQ-026 In RESP, only the owner's resp_valid SHALL be high; resp_rdata and resp_err SHALL hold stable until the owner's resp_ready is high.
REQ-027 When the owner's resp_ready is high in RESP, the FSM SHALL return to IDLE.
REQ-028 Latency SHALL be: accept in cycle N, memory access in N+1, resp_valid first high in N+2; peak throughput SHALL be one access per 3 cycles.
REQ-029 req_ready SHALL be 0 in ACCESS and RESP; a requester SHALL hold valid until it is accepted.
REQ-030 Outside ACCESS, mem_write_enable SHALL be 0, and mem_idx and mem_write_data SHALL hold their last values.

Reset
REQ-031 Asserting rst_n=0 in any state SHALL force IDLE and priority to A, and SHALL zero all outputs: req_ready, resp_valid, resp_rdata, resp_err, mem_idx, mem_write_data and mem_write_enable.
REQ-032 A reset asserted during ACCESS SHALL deassert mem_write_enable immediately; any in-flight request SHALL be dropped and produce no response.

Structure
REQ-033 The types Clock, Addr, Data and Bool, plus the arbiter state enum, SHALL live in the shared package.
REQ-034 The round-robin select SHALL be one sub-module, rr_arbiter2, with inputs req[1:0] and last, and a one-hot grant output.

Verification
REQ-035 A bench SHALL drive an A write of addr 0x8 = 0x1234 followed by an A read of 0x8, and check mem_write_enable high for exactly one cycle and resp_rdata=0x1234 at N+2.
REQ-036 A bench SHALL drive A and B valid together for 4 transactions, and check the grant order A, B, A, B.
REQ-037 A bench SHALL drive a B write to addr 0x200 with MEM_BYTES=512, and check resp_err=1, no write strobe, and memory unchanged.
REQ-038 A bench SHALL hold a_resp_ready low for 5 cycles, and check resp_valid and resp_rdata stable with b_req_ready=0 throughout.
REQ-039 A bench SHALL pulse rst_n low during ACCESS of a write, and check mem_write_enable=0 immediately, no resp_valid, and the next grant going to A.
REQ-040 A bench SHALL drive a read of addr 0x7 and check that it returns the word at index 1.
